// File: rtl/mips_pkg.sv
// mips_pkg: shared MULT decode constant, multiplier state encoding and default width
package mips_pkg;
  localparam logic [5:0] MULT_FUNCT = 6'h18;
  localparam int DEF_WIDTH = 32;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;
endpackage

// File: rtl/booth_step.sv
// booth_step: one radix-2 Booth add/sub followed by arithmetic right shift of {A,Q,q_m1}
module booth_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0]   a,
  input  logic [WIDTH-1:0] q,
  input  logic             q_m1,
  input  logic [WIDTH:0]   m,
  output logic [WIDTH:0]   a_next,
  output logic [WIDTH-1:0] q_next,
  output logic             q_m1_next
);
  logic [WIDTH:0] s;
  always_comb begin
    s = (q[0] && !q_m1) ? a - m : (!q[0] && q_m1) ? a + m : a;
    a_next = {s[WIDTH], s[WIDTH:1]};
    q_next = {s[0], q[WIDTH-1:1]};
    q_m1_next = q[0];
  end
endmodule

// File: rtl/booth_mul_seq.sv
// booth_mul_seq: multi-cycle radix-2 Booth signed multiplier with HI/LO product registers
module booth_mul_seq
  import mips_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             flush,
  input  logic [WIDTH-1:0] mcand,
  input  logic [WIDTH-1:0] mplier,
  output logic             stall,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam int CW = $clog2(WIDTH) + 1;
  state_t state;
  logic [WIDTH:0] m, a, na;
  logic [WIDTH-1:0] q, nq;
  logic qm1, nqm1, done_q;
  logic [CW-1:0] count;
  booth_step #(.WIDTH(WIDTH)) u_step (
    .a(a), .q(q), .q_m1(qm1), .m(m),
    .a_next(na), .q_next(nq), .q_m1_next(nqm1)
  );
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      count <= '0;
      m <= '0;
      a <= '0;
      q <= '0;
      qm1 <= 1'b0;
      hi <= '0;
      lo <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: if (start && !flush) begin
          state <= RUN;
          m <= {mcand[WIDTH-1], mcand};
          a <= '0;
          q <= mplier;
          qm1 <= 1'b0;
          count <= CW'(WIDTH);
        end
        RUN: if (flush) state <= IDLE;
        else begin
          a <= na;
          q <= nq;
          qm1 <= nqm1;
          count <= count - 1'b1;
          // the final step's result goes straight into HI/LO on DONE entry
          if (count == CW'(1)) begin
            state <= DONE;
            hi <= na[WIDTH-1:0];
            lo <= nq;
            done_q <= 1'b1;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
  assign done = done_q && !flush;
  assign busy = state != IDLE;
  assign stall = (state == IDLE && start) || state == RUN;
endmodule

// File: tb/tb_booth_mul_seq.sv
// tb_booth_mul_seq: scoreboard bench for booth_mul_seq with directed hand-computed vectors
module tb_booth_mul_seq;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, flush = 1'b0;
  logic [31:0] mcand = '0, mplier = '0;
  logic stall, busy, done;
  logic [31:0] hi, lo;
  int checks = 0, failures = 0;
  logic [63:0] sb[$];
  booth_mul_seq #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .flush(flush), .mcand(mcand), .mplier(mplier),
    .stall(stall), .busy(busy), .done(done), .hi(hi), .lo(lo)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  always @(negedge clk) if (!rst && done) begin
    if (sb.size() == 0) chk("unexpected_done", 64'd1, 64'd0);
    else chk("product", {hi, lo}, sb.pop_front());
  end
  // entered at posedge+1; returns at posedge+1 of the edge leaving DONE
  task automatic mul(input logic [31:0] x, input logic [31:0] y, input logic [63:0] e,
                     input int rep1, input int rep2);
    int stalls, cyc;
    bit seen;
    stalls = 0;
    cyc = 0;
    seen = 0;
    start = 1'b1;
    mcand = x;
    mplier = y;
    sb.push_back(e);
    for (int c = 1; c <= 60 && !seen; c++) begin
      @(negedge clk);
      if (stall) stalls++;
      if (done) begin
        seen = 1;
        cyc = c;
      end
      @(posedge clk);
      #1;
      start = (c + 1 == rep1 || c + 1 == rep2);
      mcand = start ? 32'h1234_5678 : x;
      mplier = start ? 32'h0000_0003 : y;
    end
    chk("done_seen", 64'(seen), 64'd1);
    chk("stall_cycles", 64'(stalls), 64'd33);
    chk("done_cycle", 64'(cyc), 64'd34);
  endtask
  initial begin
    #12;
    chk("rst_hi_lo", {hi, lo}, 64'd0);
    chk("rst_flags", {61'd0, stall, busy, done}, 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;
    mul(32'd3, 32'd5, 64'h0000_0000_0000_000F, 0, 0);
    mul(-32'sd7, 32'd6, 64'hFFFF_FFFF_FFFF_FFD6, 0, 0);
    mul(32'h7FFF_FFFF, 32'd2, 64'h0000_0000_FFFF_FFFE, 0, 0);
    mul(32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, 0, 0);
    mul(32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0000_0000_0000_0001, 0, 0);
    mul(32'h7FFF_FFFF, 32'h8000_0000, 64'hC000_0000_8000_0000, 0, 0);
    mul(32'd3, 32'd5, 64'h0000_0000_0000_000F, 5, 20);
    start = 1'b1;
    mcand = 32'd9;
    mplier = 32'd9;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (10) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_hi_lo", {hi, lo}, 64'd0);
    chk("async_rst_flags", {61'd0, stall, busy, done}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    mul(32'd3, 32'd5, 64'h0000_0000_0000_000F, 0, 0);
    start = 1'b1;
    flush = 1'b1;
    @(negedge clk);
    chk("flush_start_stall", 64'(stall), 64'd1);
    @(posedge clk);
    #1;
    start = 1'b0;
    flush = 1'b0;
    @(negedge clk);
    chk("flush_beats_start", 64'(busy), 64'd0);
    @(posedge clk);
    #1;
    start = 1'b1;
    mcand = 32'd9;
    mplier = 32'd9;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (11) @(posedge clk);
    #1 flush = 1'b1;
    @(negedge clk);
    chk("run_busy", 64'(busy), 64'd1);
    @(posedge clk);
    #1 flush = 1'b0;
    @(negedge clk);
    chk("flush_idle", {62'd0, busy, stall}, 64'd0);
    repeat (40) @(negedge clk);
    chk("flush_hi_lo", {hi, lo}, 64'h0000_0000_0000_000F);
    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
